// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order tag allocator and commit queue.
// Entries are allocated at the tail, completed out of order by tag from the
// result bus, and retired strictly in program order from the head.
// Every output is a function of registered state (plus flush gating on commit).
module reorder_buffer #(
  parameter int SIZE    = 8,
  parameter int NUM_CDB = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          alloc,
  input  logic [4:0]                    alloc_rd,
  output logic [3:0]                    alloc_tag,
  output logic                          full,
  output logic                          empty,
  output logic [4:0]                    count,
  input  logic [NUM_CDB-1:0]            cdb_rdy,
  input  logic [NUM_CDB-1:0][3:0]       cdb_tag,
  input  logic [NUM_CDB-1:0][31:0]      cdb_data,
  output logic [SIZE-1:0]               rob_bcast_rdy,
  output logic [SIZE-1:0][31:0]         rob_bcast_data,
  output logic                          commit_valid,
  output logic [4:0]                    commit_rd,
  output logic [31:0]                   commit_data,
  output logic [3:0]                    commit_tag
);

  localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [4:0] SIZE_C = 5'(SIZE);

  // Entry state
  logic [SIZE-1:0]        valid_q, valid_d;
  logic [SIZE-1:0]        done_q,  done_d;
  logic [SIZE-1:0][4:0]   rd_q,    rd_d;
  logic [SIZE-1:0][31:0]  data_q,  data_d;

  // Queue pointers and occupancy
  logic [PW-1:0]          head_q,  head_d;
  logic [PW-1:0]          tail_q,  tail_d;
  logic [4:0]             count_q, count_d;

  // Derived control
  logic                   full_s;
  logic                   empty_s;
  logic                   commit_valid_s;
  logic                   alloc_ok_s;
  logic [SIZE-1:0]        cdb_hit_s;
  logic [SIZE-1:0][31:0]  cdb_val_s;

  // Status flags and the commit/accept decisions, all from registered state.
  always_comb begin
    full_s         = (count_q == SIZE_C);
    empty_s        = (count_q == 5'd0);
    commit_valid_s = valid_q[head_q] & done_q[head_q] & ~flush;
    alloc_ok_s     = alloc & ~full_s;
  end

  // Resolve the result bus per entry; scanning slots upward lets the
  // highest-numbered slot carrying a tag win.
  always_comb begin
    cdb_hit_s = '0;
    cdb_val_s = '0;
    for (int s = 0; s < NUM_CDB; s++) begin
      for (int i = 0; i < SIZE; i++) begin
        if (cdb_rdy[s] && (cdb_tag[s] == 4'(i))) begin
          cdb_hit_s[i] = 1'b1;
          cdb_val_s[i] = cdb_data[s];
        end else begin
          cdb_hit_s[i] = cdb_hit_s[i];
          cdb_val_s[i] = cdb_val_s[i];
        end
      end
    end
  end

  // Next-state for entries and pointers: flush dominates, otherwise apply
  // result writes, retirement at head and allocation at tail.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = 5'd0;
    end else begin
      // Result writes land only on live entries that are not retiring now.
      for (int i = 0; i < SIZE; i++) begin
        if (cdb_hit_s[i] && valid_q[i] &&
            !(commit_valid_s && (head_q == PW'(i)))) begin
          done_d[i] = 1'b1;
          data_d[i] = cdb_val_s[i];
        end else begin
          done_d[i] = done_d[i];
          data_d[i] = data_d[i];
        end
      end

      // Retire the head entry.
      if (commit_valid_s) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + PW'(1'b1);
      end else begin
        head_d = head_q;
      end

      // Allocate at the tail; the tail slot is never live when not full,
      // so it cannot collide with the retiring head or a result write.
      if (alloc_ok_s) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        rd_d[tail_q]    = alloc_rd;
        tail_d          = tail_q + PW'(1'b1);
      end else begin
        tail_d = tail_q;
      end

      count_d = count_q + {4'b0000, alloc_ok_s} - {4'b0000, commit_valid_s};
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 5'd0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Output mapping.
  always_comb begin
    alloc_tag      = 4'(tail_q);
    full           = full_s;
    empty          = empty_s;
    count          = count_q;
    rob_bcast_rdy  = valid_q & done_q;
    rob_bcast_data = data_q;
    commit_valid   = commit_valid_s;
    commit_rd      = rd_q[head_q];
    commit_data    = data_q[head_q];
    commit_tag     = 4'(head_q);
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer (SIZE=8, NUM_CDB=8).
module tb_reorder_buffer;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              alloc;
  logic [4:0]        alloc_rd;
  logic [3:0]        alloc_tag;
  logic              full;
  logic              empty;
  logic [4:0]        count;
  logic [7:0]        cdb_rdy;
  logic [7:0][3:0]   cdb_tag;
  logic [7:0][31:0]  cdb_data;
  logic [7:0]        rob_bcast_rdy;
  logic [7:0][31:0]  rob_bcast_data;
  logic              commit_valid;
  logic [4:0]        commit_rd;
  logic [31:0]       commit_data;
  logic [3:0]        commit_tag;

  int n_pass;
  int n_total;

  reorder_buffer #(.SIZE(8), .NUM_CDB(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .alloc          (alloc),
    .alloc_rd       (alloc_rd),
    .alloc_tag      (alloc_tag),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .cdb_rdy        (cdb_rdy),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .rob_bcast_rdy  (rob_bcast_rdy),
    .rob_bcast_data (rob_bcast_data),
    .commit_valid   (commit_valid),
    .commit_rd      (commit_rd),
    .commit_data    (commit_data),
    .commit_tag     (commit_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cdb(input int slot, input logic [3:0] tag, input logic [31:0] d);
    cdb_rdy[slot]  = 1'b1;
    cdb_tag[slot]  = tag;
    cdb_data[slot] = d;
  endtask

  task automatic clr_cdb();
    cdb_rdy  = '0;
    cdb_tag  = '0;
    cdb_data = '0;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    alloc    = 1'b0;
    alloc_rd = 5'd0;
    clr_cdb();
    #2;

    // Reset state
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    chk("rst_bcast_rdy", 32'(rob_bcast_rdy), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    rst = 1'b0;

    // Three allocations rd=5,6,7
    alloc = 1'b1; alloc_rd = 5'd5;
    chk("alloc0_tag", 32'(alloc_tag), 32'd0);
    tick();
    chk("alloc1_tag", 32'(alloc_tag), 32'd1);
    alloc_rd = 5'd6;
    tick();
    chk("alloc2_tag", 32'(alloc_tag), 32'd2);
    alloc_rd = 5'd7;
    tick();
    alloc = 1'b0;
    chk("count3", 32'(count), 32'd3);
    chk("tail3", 32'(alloc_tag), 32'd3);
    chk("no_commit_a", 32'(commit_valid), 32'd0);
    chk("not_empty", 32'(empty), 32'd0);

    // Result for tag1 becomes visible next cycle, head still pending
    set_cdb(0, 4'd1, 32'h0000_00AA);
    tick();
    clr_cdb();
    chk("bcast_rdy_tag1", 32'(rob_bcast_rdy), 32'h0000_0002);
    chk("bcast_data1", rob_bcast_data[1], 32'h0000_00AA);
    chk("no_commit_b", 32'(commit_valid), 32'd0);

    // Result for tag0 unblocks two in-order commits
    set_cdb(0, 4'd0, 32'h0000_0011);
    tick();
    clr_cdb();
    chk("c0_valid", 32'(commit_valid), 32'd1);
    chk("c0_rd", 32'(commit_rd), 32'd5);
    chk("c0_data", commit_data, 32'h0000_0011);
    chk("c0_tag", 32'(commit_tag), 32'd0);
    chk("c0_count", 32'(count), 32'd3);
    tick();
    chk("c1_count", 32'(count), 32'd2);
    chk("c1_valid", 32'(commit_valid), 32'd1);
    chk("c1_rd", 32'(commit_rd), 32'd6);
    chk("c1_data", commit_data, 32'h0000_00AA);
    chk("c1_tag", 32'(commit_tag), 32'd1);
    tick();
    chk("c2_count", 32'(count), 32'd1);
    chk("c2_valid", 32'(commit_valid), 32'd0);

    // Fresh start, then fill all 8 entries
    rst = 1'b1;
    #1;
    rst = 1'b0;
    chk("rst2_count", 32'(count), 32'd0);
    for (int i = 0; i < 8; i++) begin
      alloc = 1'b1;
      alloc_rd = 5'(8 + i);
      chk("fill_tag", 32'(alloc_tag), 32'(i));
      tick();
    end
    alloc = 1'b0;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_tail_wrap", 32'(alloc_tag), 32'd0);

    // Alloc while full, with head committing in the same cycle: dropped
    set_cdb(0, 4'd0, 32'h0000_0100);
    tick();
    clr_cdb();
    chk("full_head_done", 32'(commit_valid), 32'd1);
    alloc = 1'b1; alloc_rd = 5'd20;
    chk("full_before", 32'(full), 32'd1);
    tick();
    alloc = 1'b0;
    chk("drop_count", 32'(count), 32'd7);
    chk("drop_full", 32'(full), 32'd0);
    chk("drop_tail", 32'(alloc_tag), 32'd0);
    chk("drop_head", 32'(commit_tag), 32'd1);
    chk("drop_cv", 32'(commit_valid), 32'd0);
    alloc = 1'b1; alloc_rd = 5'd21;
    tick();
    alloc = 1'b0;
    chk("wrap_full", 32'(full), 32'd1);
    chk("wrap_tail", 32'(alloc_tag), 32'd1);

    // Complete tags 1..4 and drain them in order
    for (int k = 0; k < 4; k++) set_cdb(k, 4'(k + 1), 32'h0000_0201 + 32'(k));
    tick();
    clr_cdb();
    chk("bcast_1to4", 32'(rob_bcast_rdy), 32'h0000_001E);
    for (int k = 0; k < 4; k++) begin
      chk("drain_tag", 32'(commit_tag), 32'(k + 1));
      chk("drain_data", commit_data, 32'h0000_0201 + 32'(k));
      tick();
    end
    chk("drain_count", 32'(count), 32'd4);
    chk("drain_cv", 32'(commit_valid), 32'd0);
    chk("drain_head", 32'(commit_tag), 32'd5);

    // Same-cycle alloc + commit at count 4
    set_cdb(0, 4'd5, 32'h0000_0055);
    tick();
    clr_cdb();
    chk("ac_cv", 32'(commit_valid), 32'd1);
    chk("ac_data", commit_data, 32'h0000_0055);
    alloc = 1'b1; alloc_rd = 5'd22;
    chk("ac_tag_before", 32'(alloc_tag), 32'd1);
    tick();
    alloc = 1'b0;
    chk("ac_count", 32'(count), 32'd4);
    chk("ac_tail", 32'(alloc_tag), 32'd2);
    chk("ac_head", 32'(commit_tag), 32'd6);

    // Allocate tags 2 and 3
    alloc = 1'b1; alloc_rd = 5'd23;
    tick();
    alloc_rd = 5'd24;
    tick();
    alloc = 1'b0;
    chk("count6", 32'(count), 32'd6);

    // Two slots write tag3 (higher slot wins); write to unallocated tag4 ignored
    set_cdb(2, 4'd3, 32'h0000_0001);
    set_cdb(5, 4'd3, 32'h0000_0002);
    set_cdb(7, 4'd4, 32'h0000_DEAD);
    tick();
    clr_cdb();
    chk("dup_rdy", 32'(rob_bcast_rdy), 32'h0000_0008);
    chk("dup_data3", rob_bcast_data[3], 32'h0000_0002);
    chk("inval_data4", rob_bcast_data[4], 32'h0000_0204);
    chk("dup_count", 32'(count), 32'd6);

    // Complete 6 and 7; a write to the committing entry is ignored
    set_cdb(0, 4'd6, 32'h0000_0066);
    set_cdb(1, 4'd7, 32'h0000_0077);
    tick();
    clr_cdb();
    chk("h6_cv", 32'(commit_valid), 32'd1);
    chk("h6_tag", 32'(commit_tag), 32'd6);
    set_cdb(0, 4'd6, 32'h0000_0099);
    tick();
    clr_cdb();
    chk("pre_flush_count", 32'(count), 32'd5);
    chk("pre_flush_rdy", 32'(rob_bcast_rdy), 32'h0000_0088);
    chk("commit_wr_ignored", rob_bcast_data[6], 32'h0000_0066);
    chk("pre_flush_cv", 32'(commit_valid), 32'd1);

    // Flush with concurrent alloc
    flush = 1'b1; alloc = 1'b1; alloc_rd = 5'd9;
    #1;
    chk("flush_cv_forced", 32'(commit_valid), 32'd0);
    tick();
    flush = 1'b0; alloc = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_rdy", 32'(rob_bcast_rdy), 32'd0);
    chk("flush_tail", 32'(alloc_tag), 32'd0);
    chk("flush_cv", 32'(commit_valid), 32'd0);

    // Async reset pulse between edges
    alloc = 1'b1; alloc_rd = 5'd3;
    tick();
    tick();
    alloc = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd2);
    set_cdb(0, 4'd0, 32'h0000_0005);
    tick();
    clr_cdb();
    chk("pre_rst_rdy", 32'(rob_bcast_rdy), 32'h0000_0001);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    rst = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_rdy", 32'(rob_bcast_rdy), 32'd0);
    chk("arst_tail", 32'(alloc_tag), 32'd0);
    chk("arst_data0", rob_bcast_data[0], 32'd0);
    chk("arst_cv", 32'(commit_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
